wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register data width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports a_valid / a_ready, input / output, 1 each, the ALU writeback handshake.
REQ-005 The block SHALL have ports a_reg / a_data, input, 4 / DATA_W, the ALU destination register and data.
REQ-006 The block SHALL have ports b_valid / b_ready, input / output, 1 each, the memory-load writeback handshake.
REQ-007 The block SHALL have ports b_reg / b_data, input, 4 / DATA_W, the load destination register and data.
REQ-008 The block SHALL have port stall, input, 1; when high, no request is granted.
REQ-009 The block SHALL have ports WriteReg / RegId / WriteData, output, 1 / 4 / DATA_W, the register-file write port that drives the 4-to-16 write decoder.
REQ-010 The block SHALL have port pend, output, 16, one-hot OR of destinations of valid, not-yet-granted requests.
REQ-011 The block SHALL have ports cnt_clr / wr_cnt, input 1 / output 16, clear and saturating count of committed writes.

Function
REQ-012 A handshake SHALL complete in a cycle where x_valid and x_ready are both high; x_ready SHALL be combinational from valids, stall and the priority flop.
REQ-013 With stall low and only one valid, that requester SHALL be granted (its ready high).
REQ-014 With stall low and both valid, the requester not granted most recently SHALL be granted (round robin); the loser's ready SHALL be low.
REQ-015 The priority flop last_b SHALL update on every grant: 1 when B is granted, 0 when A is granted; it SHALL hold otherwise.
REQ-016 With stall high, a_ready and b_ready SHALL both be low and last_b SHALL hold.
REQ-017 A grant SHALL register RegId and WriteData from the winner and assert WriteReg in the next cycle (latency 1); WriteReg SHALL be a one-cycle pulse per grant.
REQ-018 A cycle with no grant SHALL drive WriteReg low in the next cycle; RegId and WriteData SHALL hold their last values.
REQ-019 Both requesters targeting the same register SHALL be serialized in round-robin order, producing two WriteReg pulses in consecutive cycles; the later write wins.
REQ-020 A request SHALL wait at most one cycle while stall is low; back-to-back grants SHALL be sustained every cycle.
REQ-021 pend SHALL be combinational: bit a_reg set when a_valid and not a_ready, bit b_reg set when b_valid and not b_ready; equal ids OR together.
REQ-022 wr_cnt SHALL increment by one each cycle WriteReg is high, saturate at 16'hFFFF, and cnt_clr SHALL zero it, taking priority over the increment.
REQ-023 Requester inputs are not required to be stable while ready is low; only values sampled at a completed handshake are used.

Reset
REQ-024 While rst_n is low: WriteReg=0, RegId=4'h0, WriteData=0, last_b=1 (A wins the first conflict), wr_cnt=0.
REQ-025 Reset asserted mid-operation SHALL discard any registered but not yet presented write; a_ready/b_ready SHALL follow REQ-013..016 combinationally during reset, but no grant SHALL be captured.

Configuration
REQ-026 Macro WB_R0_DISCARD_EN, when defined, SHALL make a grant with destination 4'h0 complete the handshake but keep WriteReg low next cycle and leave wr_cnt unchanged.
REQ-027 Without WB_R0_DISCARD_EN, register 0 SHALL be written like any other register.

Verification
REQ-028 A only, a_reg=3, a_data=16'h1234 for one cycle -> a_ready=1; next cycle WriteReg=1, RegId=3, WriteData=16'h1234; wr_cnt=1.
REQ-029 After reset, A and B valid together (regs 5, 6) for two cycles -> A granted cycle 0, B cycle 1; RegId 5 then 6 on consecutive WriteReg pulses; pend=16'h0040 in cycle 0.
REQ-030 Both valid with a_reg=b_reg=7, stall=1 for 3 cycles then 0 -> no ready during stall, WriteReg=0, pend=16'h0080; then two pulses to RegId 7, final WriteData from the second winner.
REQ-031 rst_n pulled low the cycle after a grant -> WriteReg stays 0, wr_cnt=0, RegId=0; first conflict after release granted to A.
REQ-032 With WB_R0_DISCARD_EN, B writes reg 0 -> b_ready=1, WriteReg stays 0, wr_cnt unchanged; without the macro -> WriteReg=1, RegId=0.
REQ-033 wr_cnt preloaded near saturation by 65535 writes, then one more write -> wr_cnt holds 16'hFFFF; cnt_clr together with WriteReg=1 -> wr_cnt=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Round-robin arbiter merging ALU and load writebacks onto one
//             register-file write port. Optional WB_R0_DISCARD_EN drops
//             writes to register 0 after completing their handshake.
//  Revision : 1.0
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [3:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [3:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    input  logic              stall,
    output logic              WriteReg,
    output logic [3:0]        RegId,
    output logic [DATA_W-1:0] WriteData,
    output logic [15:0]       pend,
    input  logic              cnt_clr,
    output logic [15:0]       wr_cnt
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic              r_last_b;
    logic              r_write_reg;
    logic [3:0]        r_reg_id;
    logic [DATA_W-1:0] r_write_data;
    logic [15:0]       r_wr_cnt;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_grant;
    logic              w_commit;
    logic [3:0]        w_win_reg;
    logic [DATA_W-1:0] w_win_data;
    logic [15:0]       w_pend;

    always_comb begin
        // A wins a conflict only when B was the most recent winner
        w_grant_a  = !stall && a_valid && (!b_valid || r_last_b);
        w_grant_b  = !stall && b_valid && !w_grant_a;
        w_grant    = w_grant_a || w_grant_b;
        w_win_reg  = w_grant_b ? b_reg  : a_reg;
        w_win_data = w_grant_b ? b_data : a_data;
`ifdef WB_R0_DISCARD_EN
        w_commit   = w_grant && (w_win_reg != 4'h0);
`else
        w_commit   = w_grant;
`endif
        w_pend = 16'h0000;
        if (a_valid && !w_grant_a) w_pend[a_reg] = 1'b1;
        if (b_valid && !w_grant_b) w_pend[b_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b     <= 1'b1;
            r_write_reg  <= 1'b0;
            r_reg_id     <= 4'h0;
            r_write_data <= '0;
            r_wr_cnt     <= 16'h0000;
        end else begin
            r_write_reg <= w_commit;
            if (w_grant) begin
                r_last_b     <= w_grant_b;
                r_reg_id     <= w_win_reg;
                r_write_data <= w_win_data;
            end
            if (cnt_clr)
                r_wr_cnt <= 16'h0000;
            else if (r_write_reg && (r_wr_cnt != c_cnt_max))
                r_wr_cnt <= r_wr_cnt + 16'h0001;
        end
    end

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign pend      = w_pend;
    assign WriteReg  = r_write_reg;
    assign RegId     = r_reg_id;
    assign WriteData = r_write_data;
    assign wr_cnt    = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Randomized + directed bench for wb_port_arbiter against a
//             behavioural writeback-port model.
//  Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, stall = 1'b0, cnt_clr = 1'b0;
    logic [3:0]    a_reg = 4'h0, b_reg = 4'h0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, WriteReg;
    logic [3:0]    RegId;
    logic [DW-1:0] WriteData;
    logic [15:0]   pend, wr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who won most recently, the write due on the port, commit count
    int            m_last_winner;   // 0 = A, 1 = B
    logic          m_wr;
    logic [3:0]    m_id;
    logic [DW-1:0] m_data;
    int unsigned   m_cnt;

    wb_port_arbiter #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .stall(stall), .WriteReg(WriteReg), .RegId(RegId), .WriteData(WriteData),
        .pend(pend), .cnt_clr(cnt_clr), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last_winner = 1;
        m_wr   = 1'b0;
        m_id   = 4'h0;
        m_data = '0;
        m_cnt  = 0;
    endtask

    task automatic chk_port(input string tag);
        chk({tag, ".WriteReg"},  {31'd0, WriteReg}, {31'd0, m_wr});
        chk({tag, ".RegId"},     {28'd0, RegId},    {28'd0, m_id});
        chk({tag, ".WriteData"}, {16'd0, WriteData}, {16'd0, m_data});
        chk({tag, ".wr_cnt"},    {16'd0, wr_cnt},   m_cnt);
    endtask

    // One clock cycle: drive, check handshake/pend mid-cycle, advance model,
    // check registered port just after the edge. Called at posedge+1.
    task automatic step(input logic av, input logic [3:0] ar, input logic [DW-1:0] ad,
                        input logic bv, input logic [3:0] br, input logic [DW-1:0] bd,
                        input logic st, input logic clr);
        logic        ea, eb;
        logic [15:0] ep;
        logic [3:0]  wreg;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        stall = st; cnt_clr = clr;
        @(negedge clk);
        if (st) begin
            ea = 1'b0; eb = 1'b0;
        end else if (av && bv) begin
            ea = (m_last_winner == 1);
            eb = !ea;
        end else begin
            ea = av; eb = bv;
        end
        ep = 16'h0000;
        if (av && !ea) ep[ar] = 1'b1;
        if (bv && !eb) ep[br] = 1'b1;
        chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
        chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
        chk("pend",    {16'd0, pend},    {16'd0, ep});
        if (!rst_n) begin
            model_reset();
        end else begin
            if (clr) m_cnt = 0;
            else if (m_wr && m_cnt < 65535) m_cnt = m_cnt + 1;
            wreg = eb ? br : ar;
`ifdef WB_R0_DISCARD_EN
            m_wr = (ea || eb) && (wreg != 4'h0);
`else
            m_wr = ea || eb;
`endif
            if (ea || eb) begin
                m_id = wreg;
                m_data = eb ? bd : ad;
                m_last_winner = eb ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        chk_port("port");
    endtask

    task automatic rnd_step(input int stall_pct);
        step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom),
             1'($urandom_range(0, 99) < stall_pct), 1'($urandom_range(0, 99) < 3));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_port("reset");
        repeat (2) rnd_step(20);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_port("reset0");
        rst_n = 1'b1;

        // Single A write, then idle so the count becomes visible
        step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, '0, 1'b0, 1'b0);
        step(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
        chk("wr_cnt_one", {16'd0, wr_cnt}, 32'd1);

        // Conflict after reset: A first, then B
        do_reset();
        step(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b0, 1'b0);
        chk("first_conflict_id", {28'd0, RegId}, 32'd5);
        step(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b0, 1'b0);
        chk("second_conflict_id", {28'd0, RegId}, 32'd6);

        // Same destination under stall, then serialized release
        repeat (3) step(1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 16'h2222, 1'b1, 1'b0);
        step(1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 16'h2222, 1'b0, 1'b0);

        // Reset right after a grant discards the pending write
        step(1'b1, 4'd9, 16'h5A5A, 1'b0, 4'd0, '0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, 1'b0, 1'b0);
        chk("post_reset_a_wins", {28'd0, RegId}, 32'd1);

        // Register 0 write from B
        step(1'b0, 4'd0, '0, 1'b1, 4'd0, 16'hC0DE, 1'b0, 1'b0);

        repeat (3000) rnd_step(25);

        // Saturation: clear, then 65540 back-to-back A writes
        step(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
        repeat (65540) step(1'b1, 4'($urandom_range(1, 15)), DW'($urandom),
                            1'b0, 4'd0, '0, 1'b0, 1'b0);
        chk("wr_cnt_sat", {16'd0, wr_cnt}, 32'h0000FFFF);
        step(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
        chk("wr_cnt_clr", {16'd0, wr_cnt}, 32'd0);

        repeat (200) rnd_step(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
